// File: rtl/mmcm_ps_pkg.sv
// rtl/mmcm_ps_pkg.sv - shared state encoding and limit helper for the MMCM phase-shift sequencer
package mmcm_ps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_STEP,
        ST_WAIT,
        ST_DONE
    } ps_state_t;

    localparam int TO_W = 8;

    // True when one more step in direction dir (1 = up) would leave [lo, hi].
    function automatic logic step_blocked(input int pos, input int lo, input int hi, input logic dir);
        return dir ? (pos >= hi) : (pos <= lo);
    endfunction

endpackage

// File: rtl/ps_rr_arb.sv
// rtl/ps_rr_arb.sv - round-robin arbiter: lowest requester at or above the pointer, wrapping
module ps_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mmcm_ps_ctrl.sv
// rtl/mmcm_ps_ctrl.sv - arbitrates signed phase-shift requests and sequences MMCM PSEN/PSDONE steps
module mmcm_ps_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter int TCQ          = 100,
    parameter int N_REQ        = 2,
    parameter int PS_WIDTH     = 10,
    parameter int PS_MAX       = 255,
    parameter int PS_MIN       = -256,
    parameter int DONE_TIMEOUT = 63
) (
    input  logic                      clk_bufg,
    input  logic                      rst_tmp,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*PS_WIDTH-1:0] req_delta,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      resp_sat,
    output logic                      resp_timeout,
    output logic                      PSEN,
    output logic                      PSINCDEC,
    input  logic                      PSDONE,
    output logic [PS_WIDTH-1:0]       ps_pos,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_spurious
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (TCQ < 0 || N_REQ < 1 || N_REQ > 4) begin : g_param_range
    end

    ps_state_t               state;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        gnt;
    logic [N_REQ-1:0]        gnt_oh;
    logic [PS_WIDTH-1:0]     mag;
    logic                    dir;
    logic                    sat;
    logic                    fin;
    logic [TO_W-1:0]         cnt;

    logic [N_REQ-1:0]        arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic [PS_WIDTH-1:0]     sel_delta;
    logic [PS_WIDTH-1:0]     pos_next;

    ps_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        sel_delta = req_delta[int'(arb_idx)*PS_WIDTH +: PS_WIDTH];
        pos_next  = ps_pos + (dir ? PS_WIDTH'(1) : {PS_WIDTH{1'b1}});
    end

    always_ff @(posedge clk_bufg or posedge rst_tmp) begin
        if (rst_tmp) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            gnt          <= '0;
            gnt_oh       <= '0;
            mag          <= '0;
            dir          <= 1'b0;
            sat          <= 1'b0;
            fin          <= 1'b0;
            cnt          <= '0;
            ps_pos       <= '0;
            PSEN         <= 1'b0;
            PSINCDEC     <= 1'b0;
            req_ack      <= '0;
            resp_sat     <= 1'b0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            PSEN    <= 1'b0;
            req_ack <= '0;
            if (PSDONE && state != ST_WAIT)
                err_spurious <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt    <= arb_idx;
                        gnt_oh <= arb_grant;
                        // Two's-complement magnitude; the most negative delta maps to 2**(W-1).
                        mag    <= sel_delta[PS_WIDTH-1] ? (~sel_delta + 1'b1) : sel_delta;
                        dir    <= ~sel_delta[PS_WIDTH-1];
                        sat    <= 1'b0;
                        fin    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (mag == '0) begin
                        req_ack  <= gnt_oh;
                        resp_sat <= 1'b0;
                        state    <= ST_DONE;
                    end else if (step_blocked(int'($signed(ps_pos)), PS_MIN, PS_MAX, dir)) begin
                        sat      <= 1'b1;
                        req_ack  <= gnt_oh;
                        resp_sat <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        PSEN     <= 1'b1;
                        PSINCDEC <= dir;
                        cnt      <= '0;
                        state    <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finished or truncated request spends one settling cycle here before acking.
                    if (fin) begin
                        req_ack  <= gnt_oh;
                        resp_sat <= sat;
                        state    <= ST_DONE;
                    end else if (PSDONE) begin
                        ps_pos <= pos_next;
                        mag    <= mag - 1'b1;
                        if (mag == PS_WIDTH'(1)) begin
                            fin <= 1'b1;
                        end else if (step_blocked(int'($signed(pos_next)), PS_MIN, PS_MAX, dir)) begin
                            sat <= 1'b1;
                            fin <= 1'b1;
                        end else begin
                            PSEN  <= 1'b1;
                            state <= ST_STEP;
                        end
                    end else if (cnt == TO_W'(DONE_TIMEOUT - 1)) begin
                        err_timeout  <= 1'b1;
                        req_ack      <= gnt_oh;
                        resp_sat     <= sat;
                        resp_timeout <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    resp_sat     <= 1'b0;
                    resp_timeout <= 1'b0;
                    busy         <= 1'b0;
                    ptr          <= (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// tb/tb_mmcm_ps_ctrl.sv - directed self-checking bench for mmcm_ps_ctrl
module tb_mmcm_ps_ctrl;

    localparam int N_REQ = 2;
    localparam int PSW   = 10;

    logic                  clk_bufg = 1'b0;
    logic                  rst_tmp  = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*PSW-1:0]  req_delta = '0;
    logic [N_REQ-1:0]      req_ack;
    logic                  resp_sat, resp_timeout, PSEN, PSINCDEC, busy, err_timeout, err_spurious;
    logic [PSW-1:0]        ps_pos;
    logic                  psdone;

    logic model_done = 1'b0;
    logic force_done = 1'b0;
    bit   done_en    = 1'b1;
    int   done_lat   = 1;
    int   cd         = 0;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    mmcm_ps_ctrl #(
        .TCQ(100), .N_REQ(N_REQ), .PS_WIDTH(PSW), .PS_MAX(255), .PS_MIN(-256), .DONE_TIMEOUT(63)
    ) dut (
        .clk_bufg     (clk_bufg),
        .rst_tmp      (rst_tmp),
        .req_valid    (req_valid),
        .req_delta    (req_delta),
        .req_ack      (req_ack),
        .resp_sat     (resp_sat),
        .resp_timeout (resp_timeout),
        .PSEN         (PSEN),
        .PSINCDEC     (PSINCDEC),
        .PSDONE       (psdone),
        .ps_pos       (ps_pos),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    always #5 clk_bufg = ~clk_bufg;
    always @(posedge clk_bufg) cyc <= cyc + 1;

    // MMCM stand-in: PSDONE high exactly done_lat cycles after the PSEN cycle.
    always @(negedge clk_bufg) begin
        if (rst_tmp) begin
            cd <= 0;
            model_done <= 1'b0;
        end else if (PSEN && done_en) begin
            cd <= done_lat;
            model_done <= 1'b0;
        end else begin
            model_done <= (cd == 1);
            if (cd > 0) cd <= cd - 1;
        end
    end
    assign psdone = model_done | force_done;

    task automatic do_reset();
        @(negedge clk_bufg);
        req_valid  = '0;
        force_done = 1'b0;
        done_en    = 1'b1;
        rst_tmp    = 1'b1;
        @(negedge clk_bufg);
        @(negedge clk_bufg);
        rst_tmp = 1'b0;
    endtask

    task automatic start_req(input int i, input int delta, output int c0);
        @(negedge clk_bufg);
        req_delta[i*PSW +: PSW] = PSW'(delta);
        req_valid[i] = 1'b1;
        c0 = cyc;
    endtask

    task automatic wait_ack(output int idx, output int ack_cyc, output int first_psen,
                            output int pulses, output int incs, output logic s, output logic t);
        idx = -1; ack_cyc = -1; first_psen = -1; pulses = 0; incs = 0; s = 1'b0; t = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_bufg);
            if (PSEN) begin
                if (first_psen < 0) first_psen = cyc;
                pulses++;
                if (PSINCDEC) incs++;
            end
            if (req_ack != '0) begin
                for (int k = 0; k < N_REQ; k++) if (req_ack[k]) idx = k;
                ack_cyc = cyc;
                s = resp_sat;
                t = resp_timeout;
                if (idx >= 0) req_valid[idx] = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({PSEN, PSINCDEC, req_ack, resp_sat, resp_timeout, busy, err_timeout, err_spurious} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {PSEN, PSINCDEC, req_ack, resp_sat, resp_timeout, busy, err_timeout, err_spurious});
        end
        n_checks++;
        if (ps_pos !== '0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", $signed(ps_pos)); end
    endtask

    task automatic test_single_inc();
        int c0, idx, ac, fp, np, ni; logic s, t;
        do_reset();
        done_lat = 12;
        start_req(0, 3, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 0) begin n_fail++; $display("FAIL inc_ack_idx: got %0d want 0", idx); end
        n_checks++;
        if (fp - c0 !== 2) begin n_fail++; $display("FAIL inc_first_psen: got %0d want 2", fp - c0); end
        n_checks++;
        if (ac - c0 !== 42) begin n_fail++; $display("FAIL inc_ack_cycle: got %0d want 42", ac - c0); end
        n_checks++;
        if (np !== 3 || ni !== 3) begin n_fail++; $display("FAIL inc_pulses: got %0d/%0d incs want 3/3", np, ni); end
        n_checks++;
        if (ps_pos !== 10'd3 || s !== 1'b0 || t !== 1'b0) begin
            n_fail++; $display("FAIL inc_result: pos %0d sat %b tmo %b want 3 0 0", $signed(ps_pos), s, t);
        end
    endtask

    task automatic test_round_robin();
        int c0, idx, ac, fp, np, ni; logic s, t;
        do_reset();
        done_lat = 2;
        @(negedge clk_bufg);
        req_delta = {PSW'(-2), PSW'(1)};
        req_valid = 2'b11;
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 0 || np !== 1 || ps_pos !== 10'd1) begin
            n_fail++; $display("FAIL rr_first: idx %0d pulses %0d pos %0d want 0 1 1", idx, np, $signed(ps_pos));
        end
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 1 || np !== 2 || ni !== 0 || ps_pos !== 10'h3FF) begin
            n_fail++; $display("FAIL rr_second: idx %0d pulses %0d incs %0d pos %0d want 1 2 0 -1", idx, np, ni, $signed(ps_pos));
        end
        start_req(0, 0, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        @(negedge clk_bufg);
        req_delta = '0;
        req_valid = 2'b11;
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 1) begin n_fail++; $display("FAIL rr_rotate: first ack idx %0d want 1", idx); end
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 0) begin n_fail++; $display("FAIL rr_rotate_tail: second ack idx %0d want 0", idx); end
    endtask

    task automatic test_saturate();
        int c0, idx, ac, fp, np, ni; logic s, t;
        do_reset();
        done_lat = 1;
        start_req(0, 254, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (ps_pos !== 10'd254 || s !== 1'b0) begin n_fail++; $display("FAIL sat_setup: pos %0d sat %b want 254 0", $signed(ps_pos), s); end
        start_req(0, 5, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (np !== 1 || ps_pos !== 10'd255 || s !== 1'b1) begin
            n_fail++; $display("FAIL sat_truncate: pulses %0d pos %0d sat %b want 1 255 1", np, $signed(ps_pos), s);
        end
        start_req(0, 1, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (np !== 0 || ac - c0 !== 2 || s !== 1'b1 || ps_pos !== 10'd255) begin
            n_fail++; $display("FAIL sat_at_limit: pulses %0d ack %0d sat %b pos %0d want 0 2 1 255", np, ac - c0, s, $signed(ps_pos));
        end
    endtask

    task automatic test_timeout();
        int c0, idx, ac, fp, np, ni; logic s, t;
        do_reset();
        done_en = 1'b0;
        start_req(0, 2, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (np !== 1 || ac - fp !== 64) begin n_fail++; $display("FAIL tmo_timing: pulses %0d ack-psen %0d want 1 64", np, ac - fp); end
        n_checks++;
        if (t !== 1'b1 || err_timeout !== 1'b1 || ps_pos !== '0) begin
            n_fail++; $display("FAIL tmo_flags: resp %b err %b pos %0d want 1 1 0", t, err_timeout, $signed(ps_pos));
        end
        done_en = 1'b1;
    endtask

    task automatic test_spurious();
        do_reset();
        n_checks++;
        if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %b want 0", err_spurious); end
        @(negedge clk_bufg);
        force_done = 1'b1;
        @(negedge clk_bufg);
        force_done = 1'b0;
        n_checks++;
        if (err_spurious !== 1'b1 || ps_pos !== '0) begin
            n_fail++; $display("FAIL spur_flag: err %b pos %0d want 1 0", err_spurious, $signed(ps_pos));
        end
    endtask

    task automatic test_reset_mid();
        int c0, idx, ac, fp, np, ni; logic s, t;
        bit seen;
        do_reset();
        done_lat = 20;
        start_req(0, 4, c0);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk_bufg);
            if (ps_pos == 10'd1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_first_step: pos %0d want 1", $signed(ps_pos)); end
        repeat (3) @(negedge clk_bufg);
        #2 rst_tmp = 1'b1;
        #1;
        n_checks++;
        if (PSEN !== 1'b0 || ps_pos !== '0 || busy !== 1'b0 || req_ack !== '0) begin
            n_fail++; $display("FAIL mid_async: psen %b pos %0d busy %b ack %b want 0 0 0 0", PSEN, $signed(ps_pos), busy, req_ack);
        end
        @(negedge clk_bufg);
        @(negedge clk_bufg);
        rst_tmp = 1'b0;
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 0 || np !== 4 || ps_pos !== 10'd4 || s !== 1'b0) begin
            n_fail++; $display("FAIL mid_rerequest: idx %0d pulses %0d pos %0d sat %b want 0 4 4 0", idx, np, $signed(ps_pos), s);
        end
    endtask

    task automatic test_zero();
        int c0, idx, ac, fp, np, ni; logic s, t;
        do_reset();
        start_req(1, 0, c0);
        wait_ack(idx, ac, fp, np, ni, s, t);
        n_checks++;
        if (idx !== 1 || np !== 0 || ac - c0 !== 2 || s !== 1'b0 || t !== 1'b0) begin
            n_fail++; $display("FAIL zero_delta: idx %0d pulses %0d ack %0d sat %b tmo %b want 1 0 2 0 0", idx, np, ac - c0, s, t);
        end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_round_robin();
        test_saturate();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
